// File: rtl/fp_mul_arb_pkg.sv
// fp_mul_arb_pkg: shared flag indices and helpers for the multiplier arbiter
package fp_mul_arb_pkg;

    localparam int FLAG_UNDERFLOW = 0;
    localparam int FLAG_OVERFLOW  = 1;
    localparam int FLAG_INVALID   = 2;

    function automatic int fp_width(input int exponent_width, input int mantissa_width);
        return exponent_width + mantissa_width + 1;
    endfunction

    function automatic int rr_next(input int idx, input int num_req);
        return (idx + 1) % num_req;
    endfunction

endpackage

// File: rtl/floating_point_multiplier.sv
// floating_point_multiplier: combinational IEEE-style multiply; subnormals flush to zero,
// NaN results are the canonical negative quiet NaN.
module floating_point_multiplier #(
    parameter int EXPONENT_WIDTH   = 8,
    parameter int MANTISSA_WIDTH   = 23,
    parameter int ROUND_TO_NEAREST = 1
) (
    input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] a,
    input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] b,
    output logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] out,
    output logic                                   invalid,
    output logic                                   overflow,
    output logic                                   underflow
);

    localparam int EW = EXPONENT_WIDTH;
    localparam int MW = MANTISSA_WIDTH;
    localparam logic [EW+1:0] BIAS    = (EW+2)'((1 << (EW - 1)) - 1);
    localparam logic [EW+1:0] EXP_MAX = (EW+2)'((1 << EW) - 1);

    logic          sign;
    logic [EW-1:0] ea, eb;
    logic [MW-1:0] ma, mb, mant;
    logic          a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_snan, b_snan;
    logic [2*MW+1:0] prod, prod_n;
    logic          norm, guard, sticky, round_up;
    logic [MW:0]   mant_r;
    logic [EW+1:0] e_fin;

    assign sign     = a[EW+MW] ^ b[EW+MW];
    assign {ea, ma} = a[EW+MW-1:0];
    assign {eb, mb} = b[EW+MW-1:0];
    assign a_zero   = ea == '0;
    assign b_zero   = eb == '0;
    assign a_inf    = &ea && ma == '0;
    assign b_inf    = &eb && mb == '0;
    assign a_nan    = &ea && |ma;
    assign b_nan    = &eb && |mb;
    assign a_snan   = a_nan && !ma[MW-1];
    assign b_snan   = b_nan && !mb[MW-1];

    assign prod     = {{(MW+1){1'b0}}, 1'b1, ma} * {{(MW+1){1'b0}}, 1'b1, mb};
    assign norm     = prod[2*MW+1];
    assign prod_n   = norm ? prod : prod << 1;
    assign mant     = prod_n[2*MW:MW+1];
    assign guard    = prod_n[MW];
    assign sticky   = |prod_n[MW-1:0];
    assign round_up = ROUND_TO_NEAREST != 0 && guard && (sticky || mant[0]);
    assign mant_r   = {1'b0, mant} + (MW+1)'(round_up);
    // a rounding carry out of the mantissa bumps the exponent; negative wraps set the top bit
    assign e_fin    = {2'b00, ea} + {2'b00, eb} + (EW+2)'(norm) + (EW+2)'(mant_r[MW]) - BIAS;

    always_comb begin
        invalid   = 1'b0;
        overflow  = 1'b0;
        underflow = 1'b0;
        if (a_nan || b_nan || (a_zero && b_inf) || (a_inf && b_zero)) begin
            out     = {1'b1, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};
            invalid = a_snan || b_snan || (!a_nan && !b_nan);
        end else if (a_inf || b_inf) begin
            out = {sign, {EW{1'b1}}, {MW{1'b0}}};
        end else if (a_zero || b_zero) begin
            out = {sign, {(EW+MW){1'b0}}};
        end else if (e_fin[EW+1] || e_fin == '0) begin
            out       = {sign, {(EW+MW){1'b0}}};
            underflow = 1'b1;
        end else if (e_fin >= EXP_MAX) begin
            out      = ROUND_TO_NEAREST != 0 ? {sign, {EW{1'b1}}, {MW{1'b0}}}
                                             : {sign, {(EW-1){1'b1}}, 1'b0, {MW{1'b1}}};
            overflow = 1'b1;
        end else begin
            out = {sign, e_fin[EW-1:0], mant_r[MW-1:0]};
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or above pointer
module rr_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]  req,
    input  logic                enable,
    input  logic [ID_WIDTH-1:0] pointer,
    output logic [NUM_REQ-1:0]  grant,
    output logic [ID_WIDTH-1:0] grant_idx
);

    logic                any;
    logic [ID_WIDTH-1:0] idx;

    // scan from the farthest offset down so the closest request to pointer wins
    always_comb begin
        any       = 1'b0;
        idx       = '0;
        grant_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = ID_WIDTH'((int'(pointer) + k) % NUM_REQ);
            if (req[idx]) begin
                any       = 1'b1;
                grant_idx = idx;
            end
        end
        grant = (enable && any) ? (NUM_REQ'(1) << grant_idx) : '0;
    end

endmodule

// File: rtl/fp_mul_arbiter.sv
// fp_mul_arbiter: round-robin sharing of one FP multiplier among NUM_REQ requesters
// through a 2-stage operand/result pipeline with sticky exception flags.
module fp_mul_arbiter
    import fp_mul_arb_pkg::*;
#(
    parameter int NUM_REQ          = 4,
    parameter int EXPONENT_WIDTH   = 8,
    parameter int MANTISSA_WIDTH   = 23,
    parameter int ROUND_TO_NEAREST = 1,
    parameter int ID_WIDTH         = $clog2(NUM_REQ),
    localparam int FW              = fp_width(EXPONENT_WIDTH, MANTISSA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*FW-1:0] req_a,
    input  logic [NUM_REQ*FW-1:0] req_b,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [ID_WIDTH-1:0]   resp_id,
    output logic [FW-1:0]         resp_out,
    output logic [2:0]            resp_flags,
    output logic [2:0]            sticky_flags,
    input  logic                  clear_sticky
);

    logic                s1_valid;
    logic [FW-1:0]       s1_a, s1_b;
    logic [ID_WIDTH-1:0] s1_id, ptr, grant_idx;
    logic [NUM_REQ-1:0]  grant;
    logic                s2_free, s1_free, accept, advance;
    logic [FW-1:0]       mul_out;
    logic                mul_inv, mul_ovf, mul_unf;
    logic [2:0]          mul_flags;
    logic [FW-1:0]       a_arr [NUM_REQ];
    logic [FW-1:0]       b_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
        assign a_arr[i] = req_a[i*FW +: FW];
        assign b_arr[i] = req_b[i*FW +: FW];
    end

    assign s2_free   = !resp_valid || resp_ready;
    assign s1_free   = !s1_valid || s2_free;
    assign advance   = s1_valid && s2_free;
    assign accept    = |(req_valid & grant);
    assign req_ready = grant;

    // ready is held low while reset is asserted so no requester sees a phantom grant
    rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_WIDTH(ID_WIDTH)) u_arb (
        .req       (req_valid),
        .enable    (s1_free && rst_n),
        .pointer   (ptr),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    floating_point_multiplier #(
        .EXPONENT_WIDTH   (EXPONENT_WIDTH),
        .MANTISSA_WIDTH   (MANTISSA_WIDTH),
        .ROUND_TO_NEAREST (ROUND_TO_NEAREST)
    ) u_mul (
        .a         (s1_a),
        .b         (s1_b),
        .out       (mul_out),
        .invalid   (mul_inv),
        .overflow  (mul_ovf),
        .underflow (mul_unf)
    );

    always_comb begin
        mul_flags                 = '0;
        mul_flags[FLAG_INVALID]   = mul_inv;
        mul_flags[FLAG_OVERFLOW]  = mul_ovf;
        mul_flags[FLAG_UNDERFLOW] = mul_unf;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_id    <= '0;
            ptr      <= '0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_a     <= a_arr[grant_idx];
            s1_b     <= b_arr[grant_idx];
            s1_id    <= grant_idx;
            ptr      <= ID_WIDTH'(rr_next(int'(grant_idx), NUM_REQ));
        end else if (advance) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid <= 1'b0;
            resp_out   <= '0;
            resp_flags <= '0;
            resp_id    <= '0;
        end else if (advance) begin
            resp_valid <= 1'b1;
            resp_out   <= mul_out;
            resp_flags <= mul_flags;
            resp_id    <= s1_id;
        end else if (resp_ready) begin
            resp_valid <= 1'b0;
        end
    end

    // a clear coinciding with a load keeps the freshly loaded flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sticky_flags <= '0;
        else sticky_flags <= (clear_sticky ? 3'b000 : sticky_flags) | (advance ? mul_flags : 3'b000);
    end

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// tb_fp_mul_arbiter: vector table, hand sequences and a randomized scoreboard for fp_mul_arbiter
module tb_fp_mul_arbiter;

    localparam int N  = 4;
    localparam int FW = 32;
    localparam int IW = 2;

    typedef struct {
        int          req;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] out;
        logic [2:0]  flags;
        logic [2:0]  sticky;
    } vec_t;

    typedef struct {
        logic [31:0]   out;
        logic [IW-1:0] id;
        logic          in_s2;
    } item_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  req_valid = '0;
    logic [N-1:0]  req_ready;
    logic [N*FW-1:0] req_a = '0;
    logic [N*FW-1:0] req_b = '0;
    logic          resp_valid;
    logic          resp_ready = 1'b1;
    logic [IW-1:0] resp_id;
    logic [FW-1:0] resp_out;
    logic [2:0]    resp_flags;
    logic [2:0]    sticky_flags;
    logic          clear_sticky = 1'b0;

    int tests = 0;
    int fails = 0;
    vec_t  vecs [9];
    item_t pipe [$];
    logic [31:0] ra [N];
    logic [31:0] rb [N];

    fp_mul_arbiter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_a        (req_a),
        .req_b        (req_b),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_id      (resp_id),
        .resp_out     (resp_out),
        .resp_flags   (resp_flags),
        .sticky_flags (sticky_flags),
        .clear_sticky (clear_sticky)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // IEEE single multiply with round-to-nearest-even, valid for normal results
    function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p, m, rem;
        int e;
        p = 64'({1'b1, a[22:0]}) * 64'({1'b1, b[22:0]});
        e = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (p[47]) e++;
        else p = p << 1;
        m   = p >> 24;
        rem = p & 64'hFF_FFFF;
        if (rem > 64'h80_0000 || (rem == 64'h80_0000 && m[0])) m++;
        if (m[24]) begin
            m = m >> 1;
            e++;
        end
        return {a[31] ^ b[31], e[7:0], m[22:0]};
    endfunction

    function automatic logic [31:0] rand_normal();
        return {1'($urandom), 8'($urandom_range(189, 64)), 23'($urandom)};
    endfunction

    task automatic set_ops(input int i, input logic [31:0] a, input logic [31:0] b);
        req_a[i*FW +: FW] = a;
        req_b[i*FW +: FW] = b;
        ra[i] = a;
        rb[i] = b;
    endtask

    task automatic do_reset();
        req_valid    = '0;
        resp_ready   = 1'b1;
        clear_sticky = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [N-1:0] exp_ready;
        int gi;
        int ptr;
        int accepts;
        logic ev;
        logic [2:0] sticky_m;
        item_t t;

        vecs = '{
            '{2, 32'h40000000, 32'h40400000, 32'h40C00000, 3'b000, 3'b000},
            '{0, 32'h7F000000, 32'h7F000000, 32'h7F800000, 3'b010, 3'b010},
            '{1, 32'h00000000, 32'h7F800000, 32'hFFC00000, 3'b100, 3'b110},
            '{3, 32'h00800000, 32'h00800000, 32'h00000000, 3'b001, 3'b111},
            '{2, 32'hC0000000, 32'h40400000, 32'hC0C00000, 3'b000, 3'b111},
            '{1, 32'h3FC00000, 32'h3FC00000, 32'h40100000, 3'b000, 3'b111},
            '{0, 32'h7F7FFFFF, 32'h3F800000, 32'h7F7FFFFF, 3'b000, 3'b111},
            '{3, 32'hFF800000, 32'h40000000, 32'hFF800000, 3'b000, 3'b111},
            '{0, 32'h3F800001, 32'h3F800001, 32'h3F800002, 3'b000, 3'b111}
        };

        do_reset();
        #1;
        check("rst_valid", resp_valid, 0);
        check("rst_out", resp_out, 0);
        check("rst_id", resp_id, 0);
        check("rst_sticky", sticky_flags, 0);
        check("rst_ready", req_ready, 0);

        // single-op vectors: accept, one empty cycle, then the result
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            req_a = {$urandom, $urandom, $urandom, $urandom};
            req_b = {$urandom, $urandom, $urandom, $urandom};
            set_ops(vecs[i].req, vecs[i].a, vecs[i].b);
            req_valid = N'(1) << vecs[i].req;
            #1 check($sformatf("tbl%0d_ready", i), req_ready, N'(1) << vecs[i].req);
            @(negedge clk);
            req_valid = '0;
            #1 check($sformatf("tbl%0d_lat", i), resp_valid, 0);
            @(negedge clk);
            #1;
            check($sformatf("tbl%0d_valid", i), resp_valid, 1);
            check($sformatf("tbl%0d_out", i), resp_out, vecs[i].out);
            check($sformatf("tbl%0d_id", i), resp_id, vecs[i].req);
            check($sformatf("tbl%0d_flags", i), resp_flags, vecs[i].flags);
            check($sformatf("tbl%0d_sticky", i), sticky_flags, vecs[i].sticky);
        end

        // clear alone, then clear on the same edge as an overflow load
        @(negedge clk);
        clear_sticky = 1'b1;
        @(negedge clk);
        clear_sticky = 1'b0;
        #1 check("clr_alone", sticky_flags, 0);
        set_ops(1, 32'h7F000000, 32'h7F000000);
        req_valid = 4'b0010;
        @(negedge clk);
        req_valid    = '0;
        clear_sticky = 1'b1;
        @(negedge clk);
        clear_sticky = 1'b0;
        #1;
        check("clr_vs_load", sticky_flags, 3'b010);
        check("clr_vs_load_flags", resp_flags, 3'b010);

        // fairness: all requesters valid, full throughput
        for (int i = 0; i < N; i++) set_ops(i, 32'h40000000 | 32'(i), 32'h40400000 + 32'(i << 4));
        do_reset();
        req_valid = '1;
        for (int k = 0; k < 12; k++) begin
            #1;
            check($sformatf("rr%0d_ready", k), req_ready, N'(1) << (k % N));
            check($sformatf("rr%0d_valid", k), resp_valid, k >= 2);
            if (k >= 2) begin
                check($sformatf("rr%0d_id", k), resp_id, (k - 2) % N);
                check($sformatf("rr%0d_out", k), resp_out, ref_mul(ra[(k - 2) % N], rb[(k - 2) % N]));
            end
            @(negedge clk);
        end

        // backpressure: only two ops fit, S2 holds steady, then drains in order
        do_reset();
        req_valid  = '1;
        resp_ready = 1'b0;
        accepts    = 0;
        for (int k = 0; k < 5; k++) begin
            #1 accepts += $countones(req_valid & req_ready);
            if (k >= 2) begin
                check($sformatf("bp%0d_id", k), resp_id, 0);
                check($sformatf("bp%0d_out", k), resp_out, ref_mul(ra[0], rb[0]));
            end
            @(negedge clk);
        end
        #1;
        check("bp_accepts", accepts, 2);
        check("bp_ready", req_ready, 0);
        req_valid  = '0;
        resp_ready = 1'b1;
        #1;
        check("bp_drain0_valid", resp_valid, 1);
        check("bp_drain0_id", resp_id, 0);
        @(negedge clk);
        #1;
        check("bp_drain1_valid", resp_valid, 1);
        check("bp_drain1_id", resp_id, 1);
        check("bp_drain1_out", resp_out, ref_mul(ra[1], rb[1]));
        @(negedge clk);
        #1 check("bp_drain_done", resp_valid, 0);

        // asynchronous reset with both stages full
        do_reset();
        req_valid  = '1;
        resp_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", resp_valid, 0);
        check("arst_out", resp_out, 0);
        check("arst_id", resp_id, 0);
        check("arst_ready", req_ready, 0);
        @(negedge clk);
        rst_n      = 1'b1;
        req_valid  = 4'b1010;
        resp_ready = 1'b1;
        #1;
        check("arst_first_grant", req_ready, 4'b0010);
        check("arst_no_stale0", resp_valid, 0);
        @(negedge clk);
        req_valid = '0;
        #1 check("arst_no_stale1", resp_valid, 0);
        @(negedge clk);
        #1;
        check("arst_resp_valid", resp_valid, 1);
        check("arst_resp_id", resp_id, 1);

        // randomized traffic against a queue-based scoreboard
        do_reset();
        pipe.delete();
        ptr      = 0;
        sticky_m = '0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            req_valid    = N'($urandom);
            resp_ready   = $urandom_range(3) != 0;
            clear_sticky = $urandom_range(7) == 0;
            for (int i = 0; i < N; i++) set_ops(i, rand_normal(), rand_normal());
            #1;
            gi = -1;
            if (pipe.size() < 2 || resp_ready)
                for (int k = 0; k < N; k++)
                    if (gi < 0 && req_valid[(ptr + k) % N]) gi = (ptr + k) % N;
            exp_ready = gi < 0 ? '0 : N'(1) << gi;
            check("rnd_ready", req_ready, exp_ready);
            ev = pipe.size() > 0 && pipe[0].in_s2;
            check("rnd_valid", resp_valid, ev);
            if (ev) begin
                check("rnd_id", resp_id, pipe[0].id);
                check("rnd_out", resp_out, pipe[0].out);
                check("rnd_flags", resp_flags, 0);
            end
            check("rnd_sticky", sticky_flags, sticky_m);
            @(posedge clk);
            if (ev && resp_ready) void'(pipe.pop_front());
            if (pipe.size() > 0 && !pipe[0].in_s2) begin
                t = pipe.pop_front();
                t.in_s2 = 1'b1;
                pipe.push_front(t);
            end
            if (clear_sticky) sticky_m = '0;
            if (gi >= 0) begin
                pipe.push_back('{ref_mul(ra[gi], rb[gi]), IW'(gi), 1'b0});
                ptr = (gi + 1) % N;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fp_mul_arbiter.md
Name: fp_mul_arbiter

Overview:
Shares one combinational floating_point_multiplier instance among NUM_REQ independent requesters. Each requester uses a valid/ready handshake. A round-robin arbiter grants one request per cycle, and a 2-stage registered pipeline returns the tagged result with exception flags. The block also keeps sticky exception status for software or a higher-level controller.

Parameters:
NUM_REQ, 4, number of requesters (≥2)
EXPONENT_WIDTH, 8, passed to the multiplier
MANTISSA_WIDTH, 23, passed to the multiplier
ROUND_TO_NEAREST, 1, passed to the multiplier
ID_WIDTH, $clog2(NUM_REQ), width of the requester tag
(FW = EXPONENT_WIDTH+MANTISSA_WIDTH+1 is derived)

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
req_valid  in  NUM_REQ  per-requester operand valid
req_ready  out  NUM_REQ  per-requester grant/accept
req_a  in  NUM_REQ*FW  flattened operand A; slice i belongs to requester i
req_b  in  NUM_REQ*FW  flattened operand B
resp_valid  out  1  result valid
resp_ready  in  1  consumer accepts result
resp_id  out  ID_WIDTH  index of the requester that issued the op
resp_out  out  FW  product
resp_flags  out  3  {invalid, overflow, underflow} for this op
sticky_flags  out  3  OR-accumulated flags since the last clear
clear_sticky  in  1  synchronous clear of sticky_flags

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: all outputs 0; stage valids 0; round-robin pointer = 0 (requester 0 has highest priority).
- S1 operand register holds: s1_valid, s1_a, s1_b, s1_id.
- S2 result register holds: resp_valid, resp_out, resp_flags, resp_id.
- Pipeline flow:
  - s2_free = !resp_valid || resp_ready.
  - s1_free = !s1_valid || s2_free.
- Arbitration (combinational):
  - If s1_free, grant exactly one requester: the first with req_valid set, searching from the pointer upward with wrap.
  - req_ready[i] = grant[i]. At most one bit is set; all are 0 when !s1_free.
  - req_ready depends on req_valid. Requesters must not make req_valid depend on req_ready.
- Accept: req_valid[i] && req_ready[i] at an edge loads S1 with that requester's operands and s1_id = i. The pointer moves to (i+1) mod NUM_REQ. The pointer holds when nothing is granted.
- Multiplier input is S1. On an edge with s1_valid && s2_free, the multiplier outputs and s1_id are captured into S2 and resp_valid is set.
- S1 clears when it advances with no new accept in the same cycle. An advance and an accept in the same edge reload S1 (full throughput, 1 op/cycle).
- Latency: accept edge N → resp_valid high after edge N+1 (2 edges, no stalls).
- Backpressure: while resp_valid && !resp_ready, S2 is held and all its outputs stay stable. S1 holds if full. At most 2 ops are in flight.
- resp handshake: the transfer completes on resp_valid && resp_ready. resp_valid drops the next cycle unless S1 advanced.
- Sticky flags: on each S2 load, sticky_flags |= new flags. clear_sticky zeroes them. If a clear and a flag-raising load occur in the same edge, the new flags are kept (the load wins).
- Unrequested requesters: their operand slices are ignored; no X-propagation into S1.
- Reset mid-operation: in-flight ops are discarded; no response is produced for them.
- Requester 0's slice is bits [FW-1:0].

Decomposition:
- Package fp_mul_arb_pkg holds:
  - flag bit indices: FLAG_UNDERFLOW=0, FLAG_OVERFLOW=1, FLAG_INVALID=2;
  - the FW derivation helper;
  - a function returning the round-robin next index.
- Sub-module rr_arbiter (NUM_REQ; in: req, enable, pointer; out: one-hot grant, grant index). Pure combinational.
- Datapath: one instance of floating_point_multiplier between S1 and S2.

Test Plan:
1. Single op. Requester 2 sends a=0x40000000, b=0x40400000 (2.0 × 3.0) with resp_ready=1 → resp_out=0x40C00000, resp_id=2, flags=000, resp_valid exactly 2 edges after accept.
2. Round-robin fairness. All 4 req_valid held high, resp_ready=1 → accepts and resp_id sequence 0,1,2,3,0,1…, one result per cycle after fill.
3. Exceptions.
   - 0x7F000000 × 0x7F000000 → 0x7F800000, flags=010.
   - Then 0x00000000 × 0x7F800000 → 0xFFC00000, flags=100.
   - sticky_flags=110.
   - Pulse clear_sticky in the same cycle a flag-raising result loads → the new flags remain set.
4. Backpressure. resp_ready=0 for 5 cycles with all requesters valid → exactly 2 accepts, then req_ready=0. resp_out/resp_id stay stable. On release, results drain in order with no loss or duplication.
5. Async reset mid-flight. Assert rst_n low between edges with S1 and S2 full → outputs zero immediately. After release: no stale response, pointer=0, first grant goes to the lowest valid index.
